// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, the data-memory controller
// state type, the default memory depth and the memory-stage decoder.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam int MEM_WORDS_DEFAULT = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic        is_mem;
        logic        is_write;
        logic [63:0] addr;
        logic [63:0] wdata;
    } dmem_op_t;

    // Map an instruction onto its single data-memory transaction.
    function automatic dmem_op_t decode_op(input logic [3:0]  icode,
                                           input logic [63:0] val_a,
                                           input logic [63:0] val_e,
                                           input logic [63:0] val_p);
        dmem_op_t op;
        op.is_mem   = 1'b1;
        op.is_write = 1'b0;
        op.addr     = val_e;
        op.wdata    = val_a;
        case (icode)
            IRMMOVQ: op.is_write = 1'b1;
            IMRMOVQ: op.is_write = 1'b0;
            ICALL: begin
                op.is_write = 1'b1;
                op.wdata    = val_p;
            end
            IRET:    op.addr = val_a;
            IPUSHQ:  op.is_write = 1'b1;
            IPOPQ:   op.addr = val_a;
            default: op.is_mem = 1'b0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/dmem_watchdog.sv
// Request watchdog: counts REQ cycles that pass without an acknowledge and
// flags the cycle in which the limit is reached.
module dmem_watchdog #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear has priority; otherwise count each enabled cycle.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The count starts at 0 in the first REQ cycle, so LIMIT-1 marks the
    // LIMIT-th cycle without an acknowledge.
    assign expired = (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/dmem_initiator.sv
// Memory-stage controller for the Y86 core: decodes one data-memory
// transaction per start strobe and runs it over a req/ack handshake.
// Optional request timeout enabled by defining DMEM_TIMEOUT_EN.
module dmem_initiator
    import y86_pkg::*;
#(
    parameter int MEM_WORDS      = MEM_WORDS_DEFAULT,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic        mreq,
    output logic        mwe,
    output logic [63:0] maddr,
    output logic [63:0] mwdata,
    input  logic        mack,
    input  logic [63:0] mrdata,
    output logic [63:0] valM,
    output logic        done,
    output logic        busy,
    output logic        dmem_error
);
    dmem_state_t state_q, state_d;
    logic        mwe_q, mwe_d;
    logic [63:0] maddr_q, maddr_d;
    logic [63:0] mwdata_q, mwdata_d;
    logic [63:0] valm_q, valm_d;
    logic        err_q, err_d;
    dmem_op_t    op;

    assign op = decode_op(icode, valA, valE, valP);

`ifdef DMEM_TIMEOUT_EN
    logic wd_expired;

    // Held clear outside REQ so every request starts counting from zero.
    dmem_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != REQ),
        .enable (state_q == REQ && !mack),
        .expired(wd_expired)
    );
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    // Next-state and datapath decisions for the IDLE/REQ/DONE sequence.
    always_comb begin
        state_d  = state_q;
        mwe_d    = mwe_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        valm_d   = valm_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                    if (op.is_mem) begin
                        // Full 64-bit compare: high address bits must not alias.
                        if (op.addr >= 64'(MEM_WORDS)) begin
                            err_d = 1'b1;
                        end else begin
                            mwe_d    = op.is_write;
                            maddr_d  = op.addr;
                            mwdata_d = op.wdata;
                            state_d  = REQ;
                        end
                    end
                end
            end
            REQ: begin
                if (mack) begin
                    if (!mwe_q) begin
                        valm_d = mrdata;
                    end
                    state_d = DONE;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers; reset aborts any request immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            valm_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            valm_q   <= valm_d;
            err_q    <= err_d;
        end
    end

    assign mreq       = (state_q == REQ);
    assign mwe        = mwe_q;
    assign maddr      = maddr_q;
    assign mwdata     = mwdata_q;
    assign valM       = valm_q;
    assign done       = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign dmem_error = err_q;

endmodule

// File: tb/tb_dmem_initiator.sv
// Directed bench for dmem_initiator; define DMEM_TIMEOUT_EN to also cover
// the request timeout (bench sets TIMEOUT_CYCLES to 4).
module tb_dmem_initiator;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic [63:0] valA = '0, valE = '0, valP = '0;
    logic        mreq, mwe;
    logic [63:0] maddr, mwdata;
    logic        mack = 1'b0;
    logic [63:0] mrdata = '0;
    logic [63:0] valM;
    logic        done, busy, dmem_error;

    int n_cmp = 0;
    int n_bad = 0;

    int mreq_cnt, done_cnt, done_cyc, bad_ctl;
    logic err_seen;

    always #5 clk = ~clk;

    dmem_initiator #(
        .MEM_WORDS     (1024),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .icode     (icode),
        .valA      (valA),
        .valE      (valE),
        .valP      (valP),
        .mreq      (mreq),
        .mwe       (mwe),
        .maddr     (maddr),
        .mwdata    (mwdata),
        .mack      (mack),
        .mrdata    (mrdata),
        .valM      (valM),
        .done      (done),
        .busy      (busy),
        .dmem_error(dmem_error)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One transaction: start pulse, then 10 sampled cycles. The memory acks
    // in the ack_at-th mreq cycle (0 = never). dbl re-strobes start while busy.
    task automatic run_txn(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                           input logic [63:0] p, input int ack_at, input logic [63:0] rd,
                           input logic exp_we, input logic [63:0] exp_addr,
                           input logic [63:0] exp_data, input bit dbl);
        mreq_cnt = 0; done_cnt = 0; done_cyc = -1; bad_ctl = 0; err_seen = 1'b0;
        @(negedge clk);
        start = 1'b1; icode = ic; valA = a; valE = e; valP = p;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (mreq) begin
                mreq_cnt++;
                if (mwe !== exp_we || maddr !== exp_addr || (exp_we && mwdata !== exp_data))
                    bad_ctl++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                err_seen = dmem_error;
            end
            if (mreq && ack_at != 0 && mreq_cnt == ack_at) begin
                mack = 1'b1; mrdata = rd;
            end else begin
                mack = 1'b0; mrdata = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            if (dbl && cyc == 1 && busy) begin
                start = 1'b1; icode = IRMMOVQ; valE = 64'h30; valA = 64'h1;
            end else begin
                start = 1'b0;
            end
        end
        mack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_mreq", {63'd0, mreq}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_valM", valM, 64'd0);
        chk("rst_maddr", maddr, 64'd0);
        rst = 1'b0;

        // rmmovq, ack in third REQ cycle
        run_txn(IRMMOVQ, 64'hDEAD, 64'h10, 64'h0, 3, 64'h0, 1'b1, 64'h10, 64'hDEAD, 1'b0);
        chk("rmmovq_mreq_cycles", 64'(mreq_cnt), 64'd3);
        chk("rmmovq_ctl_stable", 64'(bad_ctl), 64'd0);
        chk("rmmovq_done_count", 64'(done_cnt), 64'd1);
        chk("rmmovq_done_cycle", 64'(done_cyc), 64'd4);
        chk("rmmovq_err", {63'd0, err_seen}, 64'd0);

        // popq, ack in first REQ cycle
        run_txn(IPOPQ, 64'h20, 64'h999, 64'h0, 1, 64'h1234, 1'b0, 64'h20, 64'h0, 1'b0);
        chk("popq_valM", valM, 64'h1234);
        chk("popq_done_cycle", 64'(done_cyc), 64'd2);
        chk("popq_mreq_cycles", 64'(mreq_cnt), 64'd1);
        chk("popq_ctl_stable", 64'(bad_ctl), 64'd0);

        // call to the last word
        run_txn(ICALL, 64'h777, 64'h3FF, 64'h55, 2, 64'h0, 1'b1, 64'h3FF, 64'h55, 1'b0);
        chk("call_mreq_cycles", 64'(mreq_cnt), 64'd2);
        chk("call_ctl_stable", 64'(bad_ctl), 64'd0);
        chk("call_err", {63'd0, err_seen}, 64'd0);
        chk("call_valM_kept", valM, 64'h1234);

        // mrmovq one past the end
        run_txn(IMRMOVQ, 64'h0, 64'h400, 64'h0, 1, 64'hFFFF, 1'b0, 64'h400, 64'h0, 1'b0);
        chk("oob_mreq_cycles", 64'(mreq_cnt), 64'd0);
        chk("oob_done_cycle", 64'(done_cyc), 64'd1);
        chk("oob_err", {63'd0, err_seen}, 64'd1);
        chk("oob_err_held", {63'd0, dmem_error}, 64'd1);
        chk("oob_valM_kept", valM, 64'h1234);

        // address with only a high bit set must not alias to a valid word
        run_txn(IMRMOVQ, 64'h0, 64'h1000_0000_0000_0010, 64'h0, 1, 64'hFFFF, 1'b0, 64'h10, 64'h0, 1'b0);
        chk("hiaddr_mreq_cycles", 64'(mreq_cnt), 64'd0);
        chk("hiaddr_err", {63'd0, err_seen}, 64'd1);

        // ret reads via valA; error flag clears on the next accepted start
        run_txn(IRET, 64'h3FE, 64'h5, 64'h0, 2, 64'hABCD, 1'b0, 64'h3FE, 64'h0, 1'b0);
        chk("ret_valM", valM, 64'hABCD);
        chk("ret_err", {63'd0, err_seen}, 64'd0);
        chk("ret_ctl_stable", 64'(bad_ctl), 64'd0);

        // non-memory op with a second start while busy
        run_txn(IOPQ, 64'h1, 64'h2, 64'h3, 1, 64'h0, 1'b0, 64'h0, 64'h0, 1'b1);
        chk("opq_mreq_cycles", 64'(mreq_cnt), 64'd0);
        chk("opq_done_count", 64'(done_cnt), 64'd1);
        chk("opq_done_cycle", 64'(done_cyc), 64'd1);
        chk("opq_valM_kept", valM, 64'hABCD);
        chk("opq_err", {63'd0, err_seen}, 64'd0);

        // reset in the middle of a request
        @(negedge clk);
        start = 1'b1; icode = IRMMOVQ; valE = 64'h40; valA = 64'h99;
        @(negedge clk);
        start = 1'b0;
        chk("rstmid_pre_mreq", {63'd0, mreq}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_mreq", {63'd0, mreq}, 64'd0);
        chk("rstmid_busy", {63'd0, busy}, 64'd0);
        chk("rstmid_maddr", maddr, 64'd0);
        chk("rstmid_mwdata", mwdata, 64'd0);
        chk("rstmid_mwe", {63'd0, mwe}, 64'd0);
        chk("rstmid_valM", valM, 64'd0);
        chk("rstmid_err", {63'd0, dmem_error}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("rstmid_no_done", 64'(done_cnt), 64'd0);

        // normal pushq after reset
        run_txn(IPUSHQ, 64'h77, 64'h8, 64'h0, 2, 64'h0, 1'b1, 64'h8, 64'h77, 1'b0);
        chk("push_mreq_cycles", 64'(mreq_cnt), 64'd2);
        chk("push_ctl_stable", 64'(bad_ctl), 64'd0);
        chk("push_done_cycle", 64'(done_cyc), 64'd3);
        chk("push_err", {63'd0, err_seen}, 64'd0);

`ifdef DMEM_TIMEOUT_EN
        // memory never answers
        run_txn(IMRMOVQ, 64'h0, 64'h50, 64'h0, 0, 64'h0, 1'b0, 64'h50, 64'h0, 1'b0);
        chk("tmo_mreq_cycles", 64'(mreq_cnt), 64'd4);
        chk("tmo_done_cycle", 64'(done_cyc), 64'd5);
        chk("tmo_done_count", 64'(done_cnt), 64'd1);
        chk("tmo_err", {63'd0, err_seen}, 64'd1);
        chk("tmo_valM_kept", valM, 64'd0);

        // ack exactly at the limit completes normally
        run_txn(IMRMOVQ, 64'h0, 64'h50, 64'h0, 4, 64'h4444, 1'b0, 64'h50, 64'h0, 1'b0);
        chk("tmo_edge_mreq_cycles", 64'(mreq_cnt), 64'd4);
        chk("tmo_edge_err", {63'd0, err_seen}, 64'd0);
        chk("tmo_edge_valM", valM, 64'h4444);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
